nonce_scheduler: RTL and testbench

Sequences the unrolled SHA-256 hashing pipeline. Accepts one work unit from the host, then issues one nonce per clock into the pipeline. It tracks every in-flight nonce through a delay line matched to the pipeline latency, tests each returning hash word against a mask, and hands golden nonces back to the host over a valid/ready handshake. It sits between the host work interface and the hashing pipe instances.

---
 rtl/nonce_scheduler.sv | 110 +++++++++++
 tb/tb_nonce_scheduler.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_scheduler.sv
// Nonce scheduler for the unrolled SHA-256 pipe: takes one work unit, issues one nonce
// per clock, tracks each slot through a latency-matched delay line and returns golden nonces.
module nonce_scheduler #(
  parameter int          LATENCY    = 67,
  // First nonce of every job; nonzero only to reach the 32-bit wrap in short runs.
  parameter logic [31:0] NONCE_BASE = 32'h0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         work_valid,
  output logic         work_ready,
  input  logic [255:0] work_midstate,
  input  logic [95:0]  work_data,
  input  logic [31:0]  match_mask,
  output logic [255:0] pipe_state,
  output logic [511:0] pipe_data,
  input  logic [31:0]  pipe_hash,
  output logic         golden_valid,
  input  logic         golden_ready,
  output logic [31:0]  golden_nonce,
  output logic         busy,
  output logic         overflow,
  output logic [31:0]  nonce_cur
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state_q, state_d;

  logic [255:0] midstate_q;
  logic [95:0]  data_q;

  // Stage 0 is the slot currently on pipe_data; stage LATENCY lines up with pipe_hash.
  logic [LATENCY:0]       vld_pipe;
  logic [LATENCY:0][31:0] nonce_pipe;

  logic accept, issue, last_issue, drained, cand;

  assign work_ready = (state_q != DRAIN);
  assign busy       = (state_q != IDLE);
  assign accept     = work_valid & work_ready;
  assign issue      = (state_q == RUN) & ~accept;
  assign last_issue = issue & (nonce_cur == 32'hFFFF_FFFF);
  // Empty once the exiting slot (if any) leaves on this edge.
  assign drained    = ~|vld_pipe[LATENCY-1:0];
  assign cand       = vld_pipe[LATENCY] & ((pipe_hash & match_mask) == 32'h0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (accept) state_d = RUN;
               else if (last_issue) state_d = DRAIN;
      DRAIN:   if (drained) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      midstate_q <= '0;
      data_q     <= '0;
      nonce_cur  <= '0;
      pipe_state <= '0;
      pipe_data  <= '0;
    end else if (accept) begin
      midstate_q <= work_midstate;
      data_q     <= work_data;
      nonce_cur  <= NONCE_BASE;
    end else if (issue) begin
      nonce_cur  <= nonce_cur + 32'd1;
      pipe_state <= midstate_q;
      pipe_data  <= {32'h0000_0280, 320'h0, 32'h8000_0000, nonce_cur, data_q};
    end
  end

  // A new job flushes the old job's in-flight slots; their nonces are don't-care.
  always_ff @(posedge clk) begin
    if (!rst_n || accept) vld_pipe <= '0;
    else                  vld_pipe <= {vld_pipe[LATENCY-1:0], issue};
  end

  always_ff @(posedge clk) begin
    nonce_pipe <= {nonce_pipe[LATENCY-1:0], nonce_cur};
  end

  // Single-entry result buffer; a candidate arriving while it is held and not consumed is lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      golden_valid <= 1'b0;
      golden_nonce <= '0;
      overflow     <= 1'b0;
    end else if (cand) begin
      if (!golden_valid || golden_ready) begin
        golden_valid <= 1'b1;
        golden_nonce <= nonce_pipe[LATENCY];
      end else begin
        overflow <= 1'b1;
      end
    end else if (golden_ready) begin
      golden_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nonce_scheduler.sv
// Bench for nonce_scheduler: queue-based slot model checked every cycle, directed
// literal checks for each scenario, and a second instance started near the nonce wrap.
module tb_nonce_scheduler;
  localparam int L = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         work_valid, work_ready, golden_valid, golden_ready, busy, overflow;
  logic [255:0] work_midstate, pipe_state;
  logic [95:0]  work_data;
  logic [31:0]  match_mask, pipe_hash, golden_nonce, nonce_cur;
  logic [511:0] pipe_data;

  logic         w_valid, w_ready, w_gv, w_busy, w_ov;
  logic [255:0] w_pstate;
  logic [511:0] w_pdata;
  logic [31:0]  w_gn, w_ncur;

  nonce_scheduler #(.LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .work_valid(work_valid), .work_ready(work_ready),
    .work_midstate(work_midstate), .work_data(work_data), .match_mask(match_mask),
    .pipe_state(pipe_state), .pipe_data(pipe_data), .pipe_hash(pipe_hash),
    .golden_valid(golden_valid), .golden_ready(golden_ready), .golden_nonce(golden_nonce),
    .busy(busy), .overflow(overflow), .nonce_cur(nonce_cur));

  nonce_scheduler #(.LATENCY(L), .NONCE_BASE(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst_n(rst_n), .work_valid(w_valid), .work_ready(w_ready),
    .work_midstate(256'h0), .work_data(96'h0), .match_mask(32'h0),
    .pipe_state(w_pstate), .pipe_data(w_pdata), .pipe_hash(32'h0),
    .golden_valid(w_gv), .golden_ready(1'b1), .golden_nonce(w_gn),
    .busy(w_busy), .overflow(w_ov), .nonce_cur(w_ncur));

  int nvec = 0, nerr = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { logic [31:0] n; int unsigned ex; } slot_t;
  slot_t        q[$];
  int unsigned  cyc = 0;
  bit           chk_en = 0;
  int           m_mode = 0;               // 0 idle, 1 issuing, 2 draining
  logic         m_gv = 0, m_ov = 0, acc, hit;
  logic [31:0]  m_gn = 0, m_ncur = 0;
  logic [255:0] m_ms = 0, m_pstate = 0;
  logic [95:0]  m_wd = 0;
  logic [511:0] m_pdata = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_mode = 0; m_gv = 0; m_ov = 0; m_gn = 0; m_ncur = 0;
      m_ms = 0; m_wd = 0; m_pstate = 0; m_pdata = 0;
      chk_en = 1;
    end else begin
      acc = work_valid && (m_mode != 2);
      hit = (q.size() > 0) && (q[0].ex == cyc);
      if (hit && ((pipe_hash & match_mask) == 0)) begin
        if (!m_gv || golden_ready) begin m_gv = 1; m_gn = q[0].n; end
        else m_ov = 1;
      end else if (m_gv && golden_ready) m_gv = 0;
      if (hit) void'(q.pop_front());
      if (acc) begin
        m_ms = work_midstate; m_wd = work_data; m_ncur = 0; q.delete(); m_mode = 1;
      end else if (m_mode == 1) begin
        m_pstate = m_ms;
        m_pdata  = {32'h0000_0280, 320'h0, 32'h8000_0000, m_ncur, m_wd};
        q.push_back('{n: m_ncur, ex: cyc + 1 + L});
        if (m_ncur == 32'hFFFF_FFFF) m_mode = 2;
        m_ncur = m_ncur + 1;
      end else if (m_mode == 2 && q.size() == 0) m_mode = 0;
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("work_ready", work_ready, m_mode != 2);
      chk("busy", busy, m_mode != 0);
      chk("nonce_cur", nonce_cur, m_ncur);
      chk("pipe_state", pipe_state, m_pstate);
      chk("pipe_data", pipe_data, m_pdata);
      chk("golden_valid", golden_valid, m_gv);
      chk("golden_nonce", golden_nonce, m_gn);
      chk("overflow", overflow, m_ov);
    end
  end

  // ---------------- pipe stand-in ----------------
  // Directed mode: hash is zero only for exiting nonces in [glo, ghi]; otherwise random.
  bit          hash_mode = 0;
  logic [31:0] glo = 5, ghi = 5;
  initial pipe_hash = 32'hFFFF_FFFF;
  always begin
    @(posedge clk); #1;
    if (hash_mode) pipe_hash = $urandom;
    else begin
      pipe_hash = 32'hFFFF_FFFF;
      if (q.size() > 0 && q[0].ex == cyc && q[0].n >= glo && q[0].n <= ghi) pipe_hash = 32'h0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst_n = 0; tick(2); rst_n = 1;
  endtask

  task automatic accept(input logic [95:0] d);
    work_valid = 1; work_data = d;
    work_midstate = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    tick(); work_valid = 0;
  endtask

  logic [31:0] masks [5] = '{32'h0, 32'h1, 32'h3, 32'h8000_0001, 32'hFFFF_FFFF};

  initial begin
    work_valid = 0; work_midstate = 0; work_data = 0; match_mask = 32'hFFFF_FFFF;
    golden_ready = 0; w_valid = 0;
    rst_n = 0; tick(2);
    chk("rst_gv", golden_valid, 0); chk("rst_busy", busy, 0); chk("rst_ready", work_ready, 1);
    chk("rst_ncur", nonce_cur, 0); chk("rst_pdata", pipe_data, 0); chk("rst_ov", overflow, 0);
    rst_n = 1;

    // single golden at nonce 5, latency L+1 after it appears on pipe_data
    accept(96'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("cnt_nonce", pipe_data[127:96], k);
      chk("cnt_pad", pipe_data[159:128], 32'h8000_0000);
      chk("cnt_len", pipe_data[511:480], 32'h0000_0280);
      chk("cnt_data", pipe_data[95:0], 96'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA);
    end
    tick(7);
    chk("g5_early", golden_valid, 0);
    tick();
    chk("g5_valid", golden_valid, 1); chk("g5_nonce", golden_nonce, 5); chk("g5_ov", overflow, 0);

    // reset in the middle of a run
    rst_n = 0; tick();
    chk("mid_gv", golden_valid, 0); chk("mid_gn", golden_nonce, 0); chk("mid_ov", overflow, 0);
    chk("mid_busy", busy, 0); chk("mid_ncur", nonce_cur, 0); chk("mid_pdata", pipe_data, 0);
    chk("mid_pstate", pipe_state, 0); chk("mid_ready", work_ready, 1);
    rst_n = 1;

    // mask 0, host stalled: first golden held, next one overflows
    match_mask = 0; golden_ready = 0;
    accept($urandom);
    tick(6);
    chk("hold_gv", golden_valid, 1); chk("hold_gn", golden_nonce, 0); chk("hold_ov0", overflow, 0);
    tick();
    chk("ovf_gv", golden_valid, 1); chk("ovf_gn", golden_nonce, 0); chk("ovf_ov", overflow, 1);

    // mask 0, host always ready: one golden per cycle
    do_reset(); golden_ready = 1;
    accept($urandom);
    tick(6);
    for (int k = 0; k < 4; k++) begin
      chk("seq_gv", golden_valid, 1); chk("seq_gn", golden_nonce, k); chk("seq_ov", overflow, 0);
      tick();
    end

    // preempt at nonce_cur=10 with goldens 5..9 in flight
    do_reset(); match_mask = 32'hFFFF_FFFF; glo = 5; ghi = 9; golden_ready = 1;
    accept($urandom);
    tick(10);
    chk("pre_ncur", nonce_cur, 10);
    accept($urandom);
    chk("pre_g5", golden_valid, 1); chk("pre_g5n", golden_nonce, 5);
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) chk("pre_restart", pipe_data[127:96], 0);
      chk("pre_flushed", golden_valid, 0);
    end
    tick();
    chk("pre_new5", golden_valid, 1); chk("pre_new5n", golden_nonce, 5);

    // randomized traffic against the model
    hash_mode = 1;
    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      work_valid = ($urandom_range(0, 39) == 0);
      work_data = {$urandom, $urandom, $urandom};
      work_midstate = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      golden_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 99) == 0) match_mask = masks[$urandom_range(0, 4)];
      tick();
    end
    rst_n = 1; work_valid = 0; golden_ready = 1;

    // wrap instance: issue FFFFFFFC..FFFFFFFF, drain, return to idle
    tick(2);
    w_valid = 1; tick(); w_valid = 0;
    chk("w_ncur0", w_ncur, 32'hFFFF_FFFC); chk("w_busy0", w_busy, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("w_nonce", w_pdata[127:96], 32'hFFFF_FFFC + k);
    end
    chk("w_drain_ready", w_ready, 0); chk("w_drain_busy", w_busy, 1); chk("w_wrap", w_ncur, 0);
    tick(4);
    chk("w_busy_late", w_busy, 1); chk("w_gn_fe", w_gn, 32'hFFFF_FFFE);
    tick();
    chk("w_idle_busy", w_busy, 0); chk("w_idle_ready", w_ready, 1);
    chk("w_gv_ff", w_gv, 1); chk("w_gn_ff", w_gn, 32'hFFFF_FFFF); chk("w_ov", w_ov, 0);
    tick();
    chk("w_gv_done", w_gv, 0);

    tick(L + 5);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
